load_unit: RTL



---
 rtl/load_unit.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/load_unit.sv
// Load path of the MEM stage: issues word-aligned reads, stalls the pipeline until
// data returns, then extracts and sign/zero-extends the addressed byte or halfword.
module load_unit #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        LOAD_BYTE,
    input  logic        LOAD_HW,
    input  logic        LOAD_WORD,
    input  logic        LOAD_UNSIGNED,
    input  logic [31:0] addr_in,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic [31:0] data_load_out,
    output logic        load_done,
    output logic        load_stall,
    output logic        load_misaligned,
    output logic        load_timeout,
    output logic [1:0]  state_dbg
);

    // Memory handshake: mem_req/mem_addr stay asserted for the whole WAIT state;
    // memory answers with a single-cycle mem_rvalid carrying mem_rdata, which is
    // only honoured while in WAIT.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int            CW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam bit            TO_EN    = (TIMEOUT_CYCLES != 0);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic          sel_byte, sel_hw, sel_word, req_any, misaligned, timeout_hit;
    logic          lat_byte, lat_hw, lat_uns;
    logic [1:0]    lat_off;

    function automatic logic [31:0] extract(input logic [31:0] w, input logic is_b,
                                            input logic is_h, input logic uns,
                                            input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = off[1] ? w[31:16] : w[15:0];
        if (is_b)      extract = uns ? {24'd0, b} : {{24{b[7]}}, b};
        else if (is_h) extract = uns ? {16'd0, h} : {{16{h[15]}}, h};
        else           extract = w;
    endfunction

    always_comb begin
        sel_byte    = LOAD_BYTE;
        sel_hw      = !LOAD_BYTE && LOAD_HW;
        sel_word    = !LOAD_BYTE && !LOAD_HW && LOAD_WORD;
        req_any     = LOAD_BYTE || LOAD_HW || LOAD_WORD;
        misaligned  = (sel_hw && addr_in[0]) || (sel_word && (addr_in[1:0] != 2'b00));
        timeout_hit = TO_EN && (cnt == CNT_LAST);
        state_nxt   = state;
        case (state)
            IDLE:    if (req_any) state_nxt = misaligned ? DONE : WAIT;
            WAIT:    if (mem_rvalid || timeout_hit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // Reset forces the stall low even if a request is still presented.
        load_stall = !rst && ((state == IDLE && req_any) || state == WAIT);
    end

    assign state_dbg = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_req         <= 1'b0;
            mem_addr        <= 32'd0;
            data_load_out   <= 32'd0;
            load_done       <= 1'b0;
            load_misaligned <= 1'b0;
            load_timeout    <= 1'b0;
            cnt             <= '0;
            lat_byte        <= 1'b0;
            lat_hw          <= 1'b0;
            lat_uns         <= 1'b0;
            lat_off         <= 2'd0;
        end else begin
            load_done       <= 1'b0;
            load_misaligned <= 1'b0;
            load_timeout    <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_any) begin
                        lat_byte <= sel_byte;
                        lat_hw   <= sel_hw;
                        lat_uns  <= LOAD_UNSIGNED;
                        lat_off  <= addr_in[1:0];
                        if (misaligned) begin
                            load_done       <= 1'b1;
                            load_misaligned <= 1'b1;
                            data_load_out   <= 32'd0;
                        end else begin
                            mem_req  <= 1'b1;
                            mem_addr <= {addr_in[31:2], 2'b00};
                            cnt      <= '0;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt + 1'b1;
                    // Returned data takes precedence over a timeout in the same cycle.
                    if (mem_rvalid) begin
                        mem_req       <= 1'b0;
                        load_done     <= 1'b1;
                        data_load_out <= extract(mem_rdata, lat_byte, lat_hw, lat_uns, lat_off);
                    end else if (timeout_hit) begin
                        mem_req       <= 1'b0;
                        load_done     <= 1'b1;
                        load_timeout  <= 1'b1;
                        data_load_out <= 32'd0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
